decode_stage: RTL and testbench

- Registered, handshaked successor to the combinational decode stage.
- Accepts {pc, insn} from fetch over valid/ready and splits out all RV32I fields.
- Generates the sign-extended immediate for every format and flags illegal encodings.
- Holds results in a 2-entry elastic buffer (output register + skid register). Execute can back-pressure without combinational ready paths, and a flush squashes in-flight entries.

---
 rtl/decode_stage_if.sv | 37 +++
 rtl/decode_stage.sv | 203 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake bundle around decode_stage: fetch pushes {pc, insn}, execute pops decoded entries.
// slave is the decode_stage side; master is the fetch/execute side that drives it.
interface decode_stage_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [AWIDTH-1:0] pc_i;
   logic [DWIDTH-1:0] insn_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [AWIDTH-1:0] pc_o;
   logic [DWIDTH-1:0] insn_o;
   logic [6:0]        opcode_o;
   logic [4:0]        rd_o;
   logic [4:0]        rs1_o;
   logic [4:0]        rs2_o;
   logic [2:0]        funct3_o;
   logic [6:0]        funct7_o;
   logic [4:0]        shamt_o;
   logic [DWIDTH-1:0] imm_o;
   logic              illegal_o;

   modport master (
      output flush_i, in_valid_i, pc_i, insn_i, out_ready_i,
      input  in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
             funct3_o, funct7_o, shamt_o, imm_o, illegal_o
   );

   modport slave (
      input  flush_i, in_valid_i, pc_i, insn_i, out_ready_i,
      output in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
             funct3_o, funct7_o, shamt_o, imm_o, illegal_o
   );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes insn on the way in, then holds results in a
// two-entry elastic buffer (output register + skid register) with flush.
module decode_stage #(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 32,
   parameter bit ZERO_UNUSED = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   decode_stage_if.slave bus
);

   if (DWIDTH != 32) begin : g_dwidth_check
      $error("decode_stage: DWIDTH must be 32");
   end

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ONE,
      S_TWO
   } state_e;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_F,
      FMT_X
   } fmt_e;

   typedef struct packed {
      logic [AWIDTH-1:0] pc;
      logic [DWIDTH-1:0] insn;
      logic [6:0]        opcode;
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [4:0]        shamt;
      logic [DWIDTH-1:0] imm;
      logic              illegal;
   } entry_t;

   logic [DWIDTH-1:0] insn;
   fmt_e              fmt;
   entry_t            dec;
   logic              use_rd;
   logic              use_rs1;
   logic              use_rs2;

   state_e            state;
   state_e            state_nxt;
   logic              in_ready_q;
   logic              accept;
   logic              consume;
   logic              load_out;
   logic              load_skid;
   logic              out_from_skid;
   entry_t            out_q;
   entry_t            skid_q;

   assign insn = bus.insn_i;

   // Every listed opcode ends in 2'b11, so a bad insn[1:0] also lands on FMT_X.
   always_comb begin
      case (insn[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
         OP_STORE:                            fmt = FMT_S;
         OP_BRANCH:                           fmt = FMT_B;
         OP_LUI, OP_AUIPC:                    fmt = FMT_U;
         OP_JAL:                              fmt = FMT_J;
         OP_OP:                               fmt = FMT_R;
         OP_FENCE:                            fmt = FMT_F;
         default:                             fmt = FMT_X;
      endcase
   end

   assign use_rd  = !(fmt inside {FMT_S, FMT_B, FMT_X});
   assign use_rs1 = !(fmt inside {FMT_U, FMT_J, FMT_X});
   assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      dec         = '0;
      dec.pc      = bus.pc_i;
      dec.insn    = insn;
      dec.opcode  = insn[6:0];
      dec.funct3  = insn[14:12];
      dec.funct7  = insn[31:25];
      dec.shamt   = (insn[6:0] == OP_IMM) ? insn[24:20] : 5'd0;
      dec.illegal = (fmt == FMT_X);
      dec.rd      = (use_rd  || !ZERO_UNUSED) ? insn[11:7]  : 5'd0;
      dec.rs1     = (use_rs1 || !ZERO_UNUSED) ? insn[19:15] : 5'd0;
      dec.rs2     = (use_rs2 || !ZERO_UNUSED) ? insn[24:20] : 5'd0;
      case (fmt)
         FMT_I:   dec.imm = {{20{insn[31]}}, insn[31:20]};
         FMT_S:   dec.imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         FMT_B:   dec.imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         FMT_U:   dec.imm = {insn[31:12], 12'b0};
         FMT_J:   dec.imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default: dec.imm = '0;
      endcase
   end

   assign accept  = bus.in_valid_i & in_ready_q;
   assign consume = (state != S_EMPTY) & bus.out_ready_i;

   // Flush wins over everything, including an accept in the same cycle.
   always_comb begin
      state_nxt     = state;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      if (bus.flush_i) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept) begin
                  state_nxt = S_ONE;
                  load_out  = 1'b1;
               end
            end
            S_ONE: begin
               if (accept && consume) begin
                  load_out = 1'b1;
               end else if (accept) begin
                  state_nxt = S_TWO;
                  load_skid = 1'b1;
               end else if (consume) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (consume) begin
                  state_nxt     = S_ONE;
                  out_from_skid = 1'b1;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != S_TWO);
      end
   end

   // NOTE: payload registers are reset as well, so data outputs read 0 during reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out) begin
            out_q <= dec;
         end else if (out_from_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= dec;
         end
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = (state != S_EMPTY);
   assign bus.pc_o        = out_q.pc;
   assign bus.insn_o      = out_q.insn;
   assign bus.opcode_o    = out_q.opcode;
   assign bus.rd_o        = out_q.rd;
   assign bus.rs1_o       = out_q.rs1;
   assign bus.rs2_o       = out_q.rs2;
   assign bus.funct3_o    = out_q.funct3;
   assign bus.funct7_o    = out_q.funct7;
   assign bus.shamt_o     = out_q.shamt;
   assign bus.imm_o       = out_q.imm;
   assign bus.illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of independently modelled entries plus
// directed checks for reset, back-pressure, flush, async reset and raw register fields.
module tb_decode_stage;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [6:0] OPS [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                                       7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   rand_ready = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
   decode_stage_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_raw ();

   decode_stage #(.DWIDTH(DW), .AWIDTH(AW), .ZERO_UNUSED(1'b1)) u_dut (
      .clk(clk), .rst(rst), .bus(bus));
   decode_stage #(.DWIDTH(DW), .AWIDTH(AW), .ZERO_UNUSED(1'b0)) u_raw (
      .clk(clk), .rst(rst), .bus(bus_raw));

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic        illegal;
   } exp_t;

   exp_t sb[$];
   exp_t sb_exp;
   exp_t sb_got;

   // Reference decode, built from signed shifts rather than bit concatenation.
   function automatic exp_t model(input logic [31:0] pc, input logic [31:0] insn, input bit zero_unused);
      exp_t e;
      logic signed [31:0] s;
      logic signed [31:0] t;
      logic [6:0] op;
      bit known, has_rd, has_rs1, has_rs2;
      s = insn;
      op = insn[6:0];
      e = '0;
      e.pc = pc;
      e.insn = insn;
      e.opcode = op;
      e.funct3 = insn[14:12];
      e.funct7 = insn[31:25];
      e.shamt = (op == 7'h13) ? insn[24:20] : 5'd0;
      known = op inside {OPS[0], OPS[1], OPS[2], OPS[3], OPS[4], OPS[5], OPS[6], OPS[7], OPS[8], OPS[9], OPS[10]};
      e.illegal = (insn[1:0] != 2'b11) || !known;
      has_rd  = known && !(op inside {7'h23, 7'h63});
      has_rs1 = known && !(op inside {7'h37, 7'h17, 7'h6F});
      has_rs2 = op inside {7'h33, 7'h23, 7'h63};
      e.rd  = (has_rd  || !zero_unused) ? insn[11:7]  : 5'd0;
      e.rs1 = (has_rs1 || !zero_unused) ? insn[19:15] : 5'd0;
      e.rs2 = (has_rs2 || !zero_unused) ? insn[24:20] : 5'd0;
      if (op inside {7'h03, 7'h13, 7'h67, 7'h73}) begin
         e.imm = s >>> 20;
      end else if (op == 7'h23) begin
         t = s >>> 25;
         e.imm = (t << 5) | 32'(insn[11:7]);
      end else if (op == 7'h63) begin
         t = s >>> 31;
         e.imm = (t << 12) | (32'(insn[7]) << 11) | (32'(insn[30:25]) << 5) | (32'(insn[11:8]) << 1);
      end else if (op inside {7'h37, 7'h17}) begin
         e.imm = insn & 32'hFFFF_F000;
      end else if (op == 7'h6F) begin
         t = s >>> 31;
         e.imm = (t << 20) | (32'(insn[19:12]) << 12) | (32'(insn[20]) << 11) | (32'(insn[30:21]) << 1);
      end
      return e;
   endfunction

   // Scoreboard: compare on consume, push on accept, drop everything on flush or reset.
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid_o && bus.out_ready_i && !bus.flush_i) begin
            sb_got = '{pc: bus.pc_o, insn: bus.insn_o, opcode: bus.opcode_o, rd: bus.rd_o,
                       rs1: bus.rs1_o, rs2: bus.rs2_o, funct3: bus.funct3_o, funct7: bus.funct7_o,
                       shamt: bus.shamt_o, imm: bus.imm_o, illegal: bus.illegal_o};
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got pc=%h insn=%h, required no output", sb_got.pc, sb_got.insn);
            end else begin
               sb_exp = sb.pop_front();
               if (sb_got !== sb_exp) begin
                  errors++;
                  $display("FAIL sb_entry: got pc=%h insn=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h sh=%0d imm=%h ill=%0b, required pc=%h insn=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h sh=%0d imm=%h ill=%0b",
                           sb_got.pc, sb_got.insn, sb_got.opcode, sb_got.rd, sb_got.rs1, sb_got.rs2, sb_got.funct3,
                           sb_got.funct7, sb_got.shamt, sb_got.imm, sb_got.illegal,
                           sb_exp.pc, sb_exp.insn, sb_exp.opcode, sb_exp.rd, sb_exp.rs1, sb_exp.rs2, sb_exp.funct3,
                           sb_exp.funct7, sb_exp.shamt, sb_exp.imm, sb_exp.illegal);
               end
            end
         end
         if (bus.flush_i) begin
            sb.delete();
         end else if (bus.in_valid_i && bus.in_ready_o) begin
            sb.push_back(model(bus.pc_i, bus.insn_i, 1'b1));
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bus.out_ready_i = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // All tasks start and end one time unit after a rising edge.
   task automatic send(input logic [31:0] pc, input logic [31:0] insn);
      int n;
      n = 0;
      bus.in_valid_i = 1'b1;
      bus.pc_i = pc;
      bus.insn_i = insn;
      @(negedge clk);
      while (!bus.in_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL send_accept: got in_ready=%0b after %0d cycles, required 1 (pc=%h)", bus.in_ready_o, n, pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.out_valid_o) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0 || bus.out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, out_valid=%0b, required 0 and 0", sb.size(), bus.out_valid_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b required 0", bus.in_ready_o); end
      checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 0", bus.pc_o); end
      checks++; if (bus.insn_o !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h required 0", bus.insn_o); end
      checks++; if (bus.imm_o !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h required 0", bus.imm_o); end
      checks++; if ({bus.rd_o, bus.rs1_o, bus.rs2_o, bus.illegal_o} !== 16'h0) begin errors++; $display("FAIL reset_fields: got rd=%0d rs1=%0d rs2=%0d ill=%0b required all 0", bus.rd_o, bus.rs1_o, bus.rs2_o, bus.illegal_o); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %0b required 0 before first edge", bus.in_ready_o); end
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %0b required 1", bus.in_ready_o); end
   endtask

   task automatic test_basic();
      bus.out_ready_i = 1'b1;
      send(32'h1000, 32'hFFF1_0093);
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b required 1", bus.out_valid_o); end
      checks++; if (bus.pc_o !== 32'h1000) begin errors++; $display("FAIL basic_pc: got %h required 00001000", bus.pc_o); end
      checks++; if (bus.rd_o !== 5'd1) begin errors++; $display("FAIL basic_rd: got %0d required 1", bus.rd_o); end
      checks++; if (bus.rs1_o !== 5'd2) begin errors++; $display("FAIL basic_rs1: got %0d required 2", bus.rs1_o); end
      checks++; if (bus.rs2_o !== 5'd0) begin errors++; $display("FAIL basic_rs2: got %0d required 0", bus.rs2_o); end
      checks++; if (bus.funct3_o !== 3'd0) begin errors++; $display("FAIL basic_funct3: got %0d required 0", bus.funct3_o); end
      checks++; if (bus.imm_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_imm: got %h required ffffffff", bus.imm_o); end
      checks++; if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL basic_illegal: got %0b required 0", bus.illegal_o); end
      idle();
      drain();
   endtask

   task automatic test_sw_jal();
      bus.out_ready_i = 1'b1;
      send(32'h1004, 32'h0051_2423);
      checks++; if (bus.rd_o !== 5'd0) begin errors++; $display("FAIL sw_rd: got %0d required 0", bus.rd_o); end
      checks++; if (bus.rs1_o !== 5'd2) begin errors++; $display("FAIL sw_rs1: got %0d required 2", bus.rs1_o); end
      checks++; if (bus.rs2_o !== 5'd5) begin errors++; $display("FAIL sw_rs2: got %0d required 5", bus.rs2_o); end
      checks++; if (bus.funct3_o !== 3'd2) begin errors++; $display("FAIL sw_funct3: got %0d required 2", bus.funct3_o); end
      checks++; if (bus.imm_o !== 32'h0000_0008) begin errors++; $display("FAIL sw_imm: got %h required 00000008", bus.imm_o); end
      send(32'h1008, 32'hFFDF_F06F);
      checks++; if (bus.pc_o !== 32'h1008) begin errors++; $display("FAIL jal_pc: got %h required 00001008", bus.pc_o); end
      checks++; if (bus.rs1_o !== 5'd0) begin errors++; $display("FAIL jal_rs1: got %0d required 0", bus.rs1_o); end
      checks++; if (bus.imm_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jal_imm: got %h required fffffffc", bus.imm_o); end
      idle();
      drain();
   endtask

   task automatic test_formats();
      logic [31:0] dir [10] = '{32'h1234_52B7, 32'hFFFF_F517, 32'hFE20_8CE3, 32'h0081_2283, 32'h0000_80E7,
                                32'h0000_0073, 32'h0FF0_000F, 32'h40B5_0533, 32'h01F5_1513, 32'h8000_0063};
      logic [31:0] rv;
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) send(32'h2000 + 32'(i * 4), dir[i]);
      idle();
      drain();
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rv = $urandom();
         if (i % 8 == 7) send(32'h3000 + 32'(i * 4), rv);
         else send(32'h3000 + 32'(i * 4), {rv[31:7], OPS[$urandom_range(0, 10)]});
      end
      idle();
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      drain();
   endtask

   task automatic test_back_to_back();
      bus.out_ready_i = 1'b0;
      send(32'h0, 32'h0010_0093);
      send(32'h4, 32'h0020_0113);
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_two: got %0b required 0", bus.in_ready_o); end
      checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL b2b_head_pc: got %h required 00000000", bus.pc_o); end
      bus.in_valid_i = 1'b1;
      bus.pc_i = 32'h8;
      bus.insn_i = 32'h0030_0193;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_held_off: got %0b required 0", bus.in_ready_o); end
      checks++; if (bus.insn_o !== 32'h0010_0093) begin errors++; $display("FAIL b2b_stable: got %h required 00100093", bus.insn_o); end
      bus.out_ready_i = 1'b1;
      send(32'h8, 32'h0030_0193);
      idle();
      drain();
   endtask

   task automatic test_flush();
      bus.out_ready_i = 1'b0;
      send(32'h40, 32'h0010_0093);
      send(32'h44, 32'h0020_0113);
      bus.flush_i = 1'b1;
      bus.in_valid_i = 1'b1;
      bus.pc_i = 32'h48;
      bus.insn_i = 32'h0030_0193;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      idle();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_two_valid: got %0b required 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_two_ready: got %0b required 1", bus.in_ready_o); end
      bus.out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_two_ghost: got %0b required 0", bus.out_valid_o); end
      bus.out_ready_i = 1'b0;
      send(32'h50, 32'h0040_0213);
      bus.flush_i = 1'b1;
      bus.pc_i = 32'h54;
      bus.insn_i = 32'h0050_0293;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      idle();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_one_drop: got %0b required 0", bus.out_valid_o); end
      bus.out_ready_i = 1'b1;
      drain();
   endtask

   task automatic test_async_reset();
      bus.out_ready_i = 1'b0;
      send(32'h80, 32'h0010_0093);
      send(32'h84, 32'h0020_0113);
      idle();
      #2;
      rst = 1'b0;
      #1;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid: got %0b required 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL areset_ready: got %0b required 0", bus.in_ready_o); end
      checks++; if (bus.pc_o !== 32'h0) begin errors++; $display("FAIL areset_pc: got %h required 0", bus.pc_o); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL areset_ready_early: got %0b required 0", bus.in_ready_o); end
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL areset_ready_rise: got %0b required 1", bus.in_ready_o); end
      bus.out_ready_i = 1'b1;
      drain();
   endtask

   task automatic test_illegal();
      bus.out_ready_i = 1'b1;
      send(32'h300, 32'h0000_0000);
      checks++; if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL ill_zero_flag: got %0b required 1", bus.illegal_o); end
      checks++; if (bus.imm_o !== 32'h0) begin errors++; $display("FAIL ill_zero_imm: got %h required 0", bus.imm_o); end
      checks++; if ({bus.rd_o, bus.rs1_o, bus.rs2_o} !== 15'h0) begin errors++; $display("FAIL ill_zero_regs: got rd=%0d rs1=%0d rs2=%0d required 0", bus.rd_o, bus.rs1_o, bus.rs2_o); end
      send(32'h304, 32'hFFF1_0091);
      checks++; if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL ill_lowbits_flag: got %0b required 1", bus.illegal_o); end
      checks++; if (bus.rd_o !== 5'd0) begin errors++; $display("FAIL ill_lowbits_rd: got %0d required 0", bus.rd_o); end
      idle();
      drain();
   endtask

   task automatic raw_send(input logic [31:0] insn);
      int n;
      n = 0;
      bus_raw.in_valid_i = 1'b1;
      bus_raw.pc_i = 32'h400;
      bus_raw.insn_i = insn;
      @(negedge clk);
      while (!bus_raw.in_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus_raw.in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL raw_accept: got in_ready=%0b required 1", bus_raw.in_ready_o);
      end
      @(posedge clk);
      #1;
      bus_raw.in_valid_i = 1'b0;
   endtask

   task automatic test_raw_fields();
      bus_raw.out_ready_i = 1'b1;
      raw_send(32'h00C5_8033);
      checks++; if ({bus_raw.rd_o, bus_raw.rs1_o, bus_raw.rs2_o} !== {5'd0, 5'd11, 5'd12}) begin errors++; $display("FAIL raw_add_regs: got rd=%0d rs1=%0d rs2=%0d required 0 11 12", bus_raw.rd_o, bus_raw.rs1_o, bus_raw.rs2_o); end
      checks++; if (bus_raw.illegal_o !== 1'b0) begin errors++; $display("FAIL raw_add_illegal: got %0b required 0", bus_raw.illegal_o); end
      raw_send(32'h0051_2423);
      checks++; if (bus_raw.rd_o !== 5'd8) begin errors++; $display("FAIL raw_sw_rd: got %0d required 8", bus_raw.rd_o); end
      checks++; if (bus_raw.imm_o !== 32'h8) begin errors++; $display("FAIL raw_sw_imm: got %h required 00000008", bus_raw.imm_o); end
      raw_send(32'h0000_0000);
      checks++; if (bus_raw.illegal_o !== 1'b1 || bus_raw.imm_o !== 32'h0) begin errors++; $display("FAIL raw_zero: got ill=%0b imm=%h required 1 0", bus_raw.illegal_o, bus_raw.imm_o); end
   endtask

   initial begin
      bus.flush_i = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.pc_i = '0;
      bus.insn_i = '0;
      bus.out_ready_i = 1'b1;
      bus_raw.flush_i = 1'b0;
      bus_raw.in_valid_i = 1'b0;
      bus_raw.pc_i = '0;
      bus_raw.insn_i = '0;
      bus_raw.out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_sw_jal();
      test_formats();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_illegal();
      test_raw_fields();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
